mem_stage_ctrl: RTL and testbench
=================================

// Module: mem_stage_ctrl
// PURPOSE
//  Memory-stage controller sitting between the X/M latch and the P/W pipeline register.
//  Non-memory instructions pass through in one cycle.
//  LW/SW run a req/ack handshake with the FPGA data RAM, which has variable latency, and
//  stall upstream until the access completes.
//  Produces the instruction, result (p), exception flag (r) and 3-bit code (e) that the
//  P/W register latches; valid_out drives that register's instr enable.
// PARAMETERS
//  ADDR_WIDTH   12   word-address bits driven to data RAM (dmem_addr = addr_in[ADDR_WIDTH-1:0])
//  MEM_TIMEOUT  16   max cycles in WAIT before abort; legal range 2..255
// PORTS
//  clock       in   1   single system clock, all flops rising-edge
//  reset       in   1   synchronous, active-high
//  valid_in    in   1   instr_in/addr_in/data_in/e_in valid this cycle
//  instr_in    in   32  instruction from X/M latch; opcode = instr_in[31:27]
//  addr_in     in   32  ALU result: effective address, or result for non-memory ops
//  data_in     in   32  store data (rd value) for SW
//  e_in        in   3   exception code from earlier stages; 0 = none
//  stall_out   out  1   upstream must hold all *_in stable while 1
//  dmem_req    out  1   request to data RAM; held until ack or abort
//  dmem_we     out  1   1 = write (SW), 0 = read (LW); valid while dmem_req=1
//  dmem_addr   out  ADDR_WIDTH  word address
//  dmem_wdata  out  32  write data
//  dmem_ack    in   1   RAM completion; sampled only while dmem_req=1
//  dmem_rdata  in   32  read data; valid in the cycle dmem_ack=1
//  valid_out   out  1   one-cycle pulse per completed instruction
//  instr_out   out  32  instruction to P/W register
//  p_out       out  32  result: loaded word (LW), addr_in otherwise, 0 on abort
//  r_out       out  1   1 = e_out nonzero
//  e_out       out  3   exception code
// BEHAVIOUR
//  - Reset: state=IDLE. All outputs 0: valid_out, stall_out, dmem_req, dmem_we, dmem_addr,
//    dmem_wdata, instr_out, p_out, r_out, e_out.
//  - Outputs are registered. Exception: stall_out is combinational.
//  - Opcode decode: LW = 5'b01000, SW = 5'b00111. All other opcodes are non-memory.
//  - FSM states: IDLE, REQ, WAIT.
//    - IDLE, valid_in, non-memory op or e_in!=0:
//      - next edge: valid_out=1; instr_out=instr_in; p_out=addr_in; e_out=e_in; r_out=|e_in.
//      - Latency 1 cycle, no stall, no RAM access.
//      - An earlier exception suppresses the memory access.
//    - IDLE, valid_in, LW/SW, e_in==0:
//      - stall_out=1 combinationally.
//      - next edge -> REQ: dmem_req=1; dmem_we=(SW); dmem_addr and dmem_wdata loaded.
//    - REQ -> WAIT unconditionally on the next edge; timeout counter cleared.
//    - REQ/WAIT, dmem_ack=1:
//      - next edge -> IDLE; dmem_req=0; valid_out=1; e_out=0; r_out=0.
//      - p_out = dmem_rdata (LW) or addr_in (SW).
//      - Minimum memory-op latency: 2 cycles (ack in REQ cycle).
//    - WAIT, no ack, counter==MEM_TIMEOUT-1:
//      - next edge -> IDLE; dmem_req=0; valid_out=1; p_out=0; e_out=3'd7; r_out=1.
//  - stall_out = (state!=IDLE) | (state==IDLE & valid_in & mem-op & e_in==0).
//    It drops in the same cycle the FSM returns to IDLE.
//  - valid_out is 0 in every cycle not listed above; instr_out/p_out/r_out/e_out hold their values.
//  - Late ack (after abort, dmem_req=0) is ignored.
//  - Reset mid-transaction: next edge dmem_req=0, state=IDLE, no valid_out pulse.
//  - Back-to-back: a new instruction is accepted in the cycle after return to IDLE.
// CONFIGURATION
//  MEM_BOUNDS_CHECK_EN
//   - Defined: LW/SW with addr_in[31:ADDR_WIDTH]!=0 and e_in==0 is not issued to RAM.
//     It completes in 1 cycle with p_out=addr_in, e_out=3'd6, r_out=1.
//   - Undefined: upper address bits are ignored and the access wraps into RAM.
// TESTING
//  1 reset=1 for 2 cycles mid-WAIT -> dmem_req=0, valid_out=0, all outputs 0 after release.
//  2 ADD (op 00000), addr_in=32'h1234 -> valid_out pulse next cycle, p_out=32'h1234, e_out=0,
//    stall_out never 1.
//  3 SW addr=5, data=32'hDEADBEEF, ack after 3 cycles -> dmem_we=1, dmem_addr=5,
//    dmem_wdata=DEADBEEF; then LW addr=5, ack with rdata=DEADBEEF -> p_out=DEADBEEF.
//  4 LW, ack never arrives, MEM_TIMEOUT=16 -> abort 16 cycles after REQ:
//    e_out=7, r_out=1, p_out=0; late ack ignored.
//  5 LW with e_in=3'd2 -> no dmem_req, 1-cycle pass-through, e_out=2, r_out=1.
//  6 MEM_BOUNDS_CHECK_EN defined, LW addr=32'h0001_0000 -> no dmem_req, e_out=6;
//    undefined -> dmem_addr=0.

Source files
------------

// File: rtl/mem_stage_ctrl_if.sv
// -----------------------------------------------------------------------------
// mem_stage_ctrl_if
// Bundles the memory-stage signals: the X/M-latch side inputs, the data RAM
// req/ack bus and the P/W-register side outputs.
//   slave  : the controller (mem_stage_ctrl)
//   master : the surrounding pipeline / data RAM (or a testbench)
// Signals:
//   valid_in, instr_in[31:0], addr_in[31:0], data_in[31:0], e_in[2:0]  upstream
//   stall_out                                                          upstream hold
//   dmem_req, dmem_we, dmem_addr[ADDR_WIDTH-1:0], dmem_wdata[31:0]     to RAM
//   dmem_ack, dmem_rdata[31:0]                                         from RAM
//   valid_out, instr_out[31:0], p_out[31:0], r_out, e_out[2:0]         to P/W reg
// -----------------------------------------------------------------------------
interface mem_stage_ctrl_if #(
    parameter int ADDR_WIDTH = 12
);
    logic                  valid_in;
    logic [31:0]           instr_in;
    logic [31:0]           addr_in;
    logic [31:0]           data_in;
    logic [2:0]            e_in;
    logic                  stall_out;
    logic                  dmem_req;
    logic                  dmem_we;
    logic [ADDR_WIDTH-1:0] dmem_addr;
    logic [31:0]           dmem_wdata;
    logic                  dmem_ack;
    logic [31:0]           dmem_rdata;
    logic                  valid_out;
    logic [31:0]           instr_out;
    logic [31:0]           p_out;
    logic                  r_out;
    logic [2:0]            e_out;

    modport slave (
        input  valid_in, instr_in, addr_in, data_in, e_in, dmem_ack, dmem_rdata,
        output stall_out, dmem_req, dmem_we, dmem_addr, dmem_wdata,
               valid_out, instr_out, p_out, r_out, e_out
    );

    modport master (
        output valid_in, instr_in, addr_in, data_in, e_in, dmem_ack, dmem_rdata,
        input  stall_out, dmem_req, dmem_we, dmem_addr, dmem_wdata,
               valid_out, instr_out, p_out, r_out, e_out
    );
endinterface

// File: rtl/mem_stage_ctrl.sv
// -----------------------------------------------------------------------------
// mem_stage_ctrl
// Memory-stage controller between the X/M latch and the P/W register.
// Non-memory ops (and ops already carrying an exception) pass through in one
// cycle. LW/SW run a req/ack handshake with a variable-latency data RAM and
// stall upstream until the access completes or times out (e_out = 7).
// Ports:
//   clock  : rising-edge system clock
//   reset  : synchronous, active-high
//   bus    : mem_stage_ctrl_if.slave (see interface header for signal list)
// Parameters:
//   ADDR_WIDTH  : word-address bits driven to RAM
//   MEM_TIMEOUT : max cycles spent in WAIT before abort (2..255)
// Build option:
//   MEM_BOUNDS_CHECK_EN : when defined, LW/SW with nonzero address bits above
//   ADDR_WIDTH are not issued and complete in one cycle with e_out = 6.
// -----------------------------------------------------------------------------
module mem_stage_ctrl #(
    parameter int ADDR_WIDTH  = 12,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic                clock,
    input  logic                reset,
    mem_stage_ctrl_if.slave     bus
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    localparam logic [4:0] OP_LW = 5'b01000;
    localparam logic [4:0] OP_SW = 5'b00111;
    localparam logic [7:0] CNT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t                state_q, state_d;
    logic [7:0]            cnt_q, cnt_d;
    logic                  req_q, req_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic                  valid_q, valid_d;
    logic [31:0]           instr_q, instr_d;
    logic [31:0]           p_q, p_d;
    logic                  r_q, r_d;
    logic [2:0]            e_q, e_d;

    logic [4:0] opcode;
    logic       is_mem;
    logic       is_sw;
    logic       no_exc;
    logic       bounds_err;
    logic       issue;

    assign opcode = bus.instr_in[31:27];
    assign is_sw  = (opcode == OP_SW);
    assign is_mem = (opcode == OP_LW) || is_sw;
    assign no_exc = (bus.e_in == 3'd0);

`ifdef MEM_BOUNDS_CHECK_EN
    assign bounds_err = is_mem && no_exc && (bus.addr_in[31:ADDR_WIDTH] != '0);
`else
    // Upper address bits are deliberately dropped; the access wraps into RAM.
    logic unused_addr_hi;
    assign unused_addr_hi = |bus.addr_in[31:ADDR_WIDTH];
    assign bounds_err     = 1'b0;
`endif

    assign issue = bus.valid_in && is_mem && no_exc && !bounds_err;

    // Combinational so upstream holds in the very cycle a memory op is seen.
    assign bus.stall_out = (state_q != IDLE) || ((state_q == IDLE) && issue);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        valid_d = 1'b0;
        instr_d = instr_q;
        p_d     = p_q;
        r_d     = r_q;
        e_d     = e_q;
        case (state_q)
            IDLE: begin
                if (issue) begin
                    state_d = REQ;
                    req_d   = 1'b1;
                    we_d    = is_sw;
                    addr_d  = bus.addr_in[ADDR_WIDTH-1:0];
                    wdata_d = bus.data_in;
                end else if (bus.valid_in && bounds_err) begin
                    valid_d = 1'b1;
                    instr_d = bus.instr_in;
                    p_d     = bus.addr_in;
                    e_d     = 3'd6;
                    r_d     = 1'b1;
                end else if (bus.valid_in) begin
                    valid_d = 1'b1;
                    instr_d = bus.instr_in;
                    p_d     = bus.addr_in;
                    e_d     = bus.e_in;
                    r_d     = |bus.e_in;
                end
            end
            REQ, WAIT: begin
                if (bus.dmem_ack) begin
                    // Inputs are still held by the stall, so instr/addr are current.
                    state_d = IDLE;
                    req_d   = 1'b0;
                    valid_d = 1'b1;
                    instr_d = bus.instr_in;
                    p_d     = we_q ? bus.addr_in : bus.dmem_rdata;
                    e_d     = 3'd0;
                    r_d     = 1'b0;
                end else if (state_q == REQ) begin
                    state_d = WAIT;
                    cnt_d   = 8'd0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    req_d   = 1'b0;
                    valid_d = 1'b1;
                    instr_d = bus.instr_in;
                    p_d     = 32'd0;
                    e_d     = 3'd7;
                    r_d     = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            valid_q <= 1'b0;
            instr_q <= 32'd0;
            p_q     <= 32'd0;
            r_q     <= 1'b0;
            e_q     <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            valid_q <= valid_d;
            instr_q <= instr_d;
            p_q     <= p_d;
            r_q     <= r_d;
            e_q     <= e_d;
        end
    end

    assign bus.dmem_req   = req_q;
    assign bus.dmem_we    = we_q;
    assign bus.dmem_addr  = addr_q;
    assign bus.dmem_wdata = wdata_q;
    assign bus.valid_out  = valid_q;
    assign bus.instr_out  = instr_q;
    assign bus.p_out      = p_q;
    assign bus.r_out      = r_q;
    assign bus.e_out      = e_q;
endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl (ADDR_WIDTH=12, MEM_TIMEOUT=16).
module tb_mem_stage_ctrl;
    logic clock;
    logic reset;
    int   n_checks;
    int   n_fail;
    int   cycles;

    mem_stage_ctrl_if #(.ADDR_WIDTH(12)) bus ();

    mem_stage_ctrl #(.ADDR_WIDTH(12), .MEM_TIMEOUT(16)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end else begin
            $display("ok   %s: %h", tag, obs);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [4:0] op, input logic [31:0] addr,
                         input logic [31:0] data, input logic [2:0] e);
        bus.valid_in = 1'b1;
        bus.instr_in = {op, 27'h0000_0AB};
        bus.addr_in  = addr;
        bus.data_in  = data;
        bus.e_in     = e;
        #1;
    endtask

    task automatic idle_inputs();
        bus.valid_in = 1'b0;
        bus.dmem_ack = 1'b0;
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_valid"}, {31'd0, bus.valid_out}, 32'd0);
        check_eq({tag, "_stall"}, {31'd0, bus.stall_out}, 32'd0);
        check_eq({tag, "_req"},   {31'd0, bus.dmem_req}, 32'd0);
        check_eq({tag, "_we"},    {31'd0, bus.dmem_we}, 32'd0);
        check_eq({tag, "_addr"},  {20'd0, bus.dmem_addr}, 32'd0);
        check_eq({tag, "_wdata"}, bus.dmem_wdata, 32'd0);
        check_eq({tag, "_instr"}, bus.instr_out, 32'd0);
        check_eq({tag, "_p"},     bus.p_out, 32'd0);
        check_eq({tag, "_r"},     {31'd0, bus.r_out}, 32'd0);
        check_eq({tag, "_e"},     {29'd0, bus.e_out}, 32'd0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset = 1'b1;
        bus.valid_in   = 1'b0;
        bus.instr_in   = 32'd0;
        bus.addr_in    = 32'd0;
        bus.data_in    = 32'd0;
        bus.e_in       = 3'd0;
        bus.dmem_ack   = 1'b0;
        bus.dmem_rdata = 32'd0;
        step();
        step();
        reset = 1'b0;
        #1;
        check_all_zero("rst");

        // ADD pass-through, no stall
        drive(5'b00000, 32'h0000_1234, 32'd0, 3'd0);
        check_eq("add_stall", {31'd0, bus.stall_out}, 32'd0);
        step();
        check_eq("add_valid", {31'd0, bus.valid_out}, 32'd1);
        check_eq("add_p", bus.p_out, 32'h0000_1234);
        check_eq("add_e", {29'd0, bus.e_out}, 32'd0);
        check_eq("add_instr", bus.instr_out, 32'h0000_00AB);
        check_eq("add_req", {31'd0, bus.dmem_req}, 32'd0);
        idle_inputs();
        step();
        check_eq("add_pulse_end", {31'd0, bus.valid_out}, 32'd0);
        check_eq("add_p_hold", bus.p_out, 32'h0000_1234);

        // SW addr 5, ack arrives in the third cycle of the access
        drive(5'b00111, 32'd5, 32'hDEAD_BEEF, 3'd0);
        check_eq("sw_stall_comb", {31'd0, bus.stall_out}, 32'd1);
        step();
        check_eq("sw_req", {31'd0, bus.dmem_req}, 32'd1);
        check_eq("sw_we", {31'd0, bus.dmem_we}, 32'd1);
        check_eq("sw_addr", {20'd0, bus.dmem_addr}, 32'd5);
        check_eq("sw_wdata", bus.dmem_wdata, 32'hDEAD_BEEF);
        step();
        step();
        check_eq("sw_wait_req", {31'd0, bus.dmem_req}, 32'd1);
        check_eq("sw_wait_stall", {31'd0, bus.stall_out}, 32'd1);
        check_eq("sw_wait_valid", {31'd0, bus.valid_out}, 32'd0);
        bus.dmem_ack = 1'b1;
        step();
        check_eq("sw_done_valid", {31'd0, bus.valid_out}, 32'd1);
        check_eq("sw_done_req", {31'd0, bus.dmem_req}, 32'd0);
        check_eq("sw_done_p", bus.p_out, 32'd5);
        check_eq("sw_done_e", {29'd0, bus.e_out}, 32'd0);

        // LW addr 5 accepted right after return to IDLE; ack in WAIT
        bus.dmem_ack = 1'b0;
        drive(5'b01000, 32'd5, 32'd0, 3'd0);
        check_eq("lw_stall_comb", {31'd0, bus.stall_out}, 32'd1);
        step();
        check_eq("lw_req", {31'd0, bus.dmem_req}, 32'd1);
        check_eq("lw_we", {31'd0, bus.dmem_we}, 32'd0);
        step();
        bus.dmem_ack   = 1'b1;
        bus.dmem_rdata = 32'hDEAD_BEEF;
        step();
        check_eq("lw_done_valid", {31'd0, bus.valid_out}, 32'd1);
        check_eq("lw_done_p", bus.p_out, 32'hDEAD_BEEF);
        check_eq("lw_done_r", {31'd0, bus.r_out}, 32'd0);
        idle_inputs();
        check_eq("lw_done_stall", {31'd0, bus.stall_out}, 32'd0);

        // LW timeout: REQ cycle plus 16 WAIT cycles with dmem_req high
        drive(5'b01000, 32'd9, 32'd0, 3'd0);
        step();
        cycles = 0;
        while (bus.dmem_req && cycles < 40) begin
            cycles++;
            step();
        end
        check_eq("to_req_cycles", cycles, 32'd17);
        check_eq("to_valid", {31'd0, bus.valid_out}, 32'd1);
        check_eq("to_e", {29'd0, bus.e_out}, 32'd7);
        check_eq("to_r", {31'd0, bus.r_out}, 32'd1);
        check_eq("to_p", bus.p_out, 32'd0);
        bus.valid_in = 1'b0;
        bus.dmem_ack = 1'b1;
        step();
        check_eq("late_ack_valid", {31'd0, bus.valid_out}, 32'd0);
        check_eq("late_ack_req", {31'd0, bus.dmem_req}, 32'd0);
        check_eq("late_ack_e_hold", {29'd0, bus.e_out}, 32'd7);
        idle_inputs();

        // LW carrying an earlier exception: no RAM access
        drive(5'b01000, 32'h0000_0040, 32'd0, 3'd2);
        check_eq("exc_stall", {31'd0, bus.stall_out}, 32'd0);
        step();
        check_eq("exc_req", {31'd0, bus.dmem_req}, 32'd0);
        check_eq("exc_valid", {31'd0, bus.valid_out}, 32'd1);
        check_eq("exc_e", {29'd0, bus.e_out}, 32'd2);
        check_eq("exc_r", {31'd0, bus.r_out}, 32'd1);
        check_eq("exc_p", bus.p_out, 32'h0000_0040);
        idle_inputs();
        step();

        // LW beyond the RAM address range
        drive(5'b01000, 32'h0001_0000, 32'd0, 3'd0);
`ifdef MEM_BOUNDS_CHECK_EN
        check_eq("oob_stall", {31'd0, bus.stall_out}, 32'd0);
        step();
        check_eq("oob_req", {31'd0, bus.dmem_req}, 32'd0);
        check_eq("oob_valid", {31'd0, bus.valid_out}, 32'd1);
        check_eq("oob_e", {29'd0, bus.e_out}, 32'd6);
        check_eq("oob_r", {31'd0, bus.r_out}, 32'd1);
        check_eq("oob_p", bus.p_out, 32'h0001_0000);
        idle_inputs();
`else
        step();
        check_eq("wrap_req", {31'd0, bus.dmem_req}, 32'd1);
        check_eq("wrap_addr", {20'd0, bus.dmem_addr}, 32'd0);
        bus.dmem_ack   = 1'b1;
        bus.dmem_rdata = 32'h0BAD_F00D;
        step();
        check_eq("wrap_valid", {31'd0, bus.valid_out}, 32'd1);
        check_eq("wrap_p", bus.p_out, 32'h0BAD_F00D);
        idle_inputs();
`endif
        step();

        // Reset asserted for two cycles while in WAIT
        drive(5'b01000, 32'd3, 32'd0, 3'd0);
        step();
        step();
        check_eq("mid_req", {31'd0, bus.dmem_req}, 32'd1);
        reset = 1'b1;
        bus.valid_in = 1'b0;
        step();
        check_eq("mid_rst_req", {31'd0, bus.dmem_req}, 32'd0);
        check_eq("mid_rst_valid", {31'd0, bus.valid_out}, 32'd0);
        step();
        reset = 1'b0;
        #1;
        check_all_zero("mid_rst");
        step();
        check_eq("post_rst_valid", {31'd0, bus.valid_out}, 32'd0);
        check_eq("post_rst_req", {31'd0, bus.dmem_req}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
